// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Owner encoding doubles as the round-robin "last served" value.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; on contention
// the requester not served last wins. grant[0]=cpu, grant[1]=dbg.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last == OWN_CPU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU sequencer and a debug loader onto one memory port,
// with a wait-cycle timeout that aborts stalled accesses.
//
// state  | meaning
// IDLE   | pick an owner, pulse its gnt, latch the request
// ACCESS | drive the memory strobe until mem_ready or timeout
// DONE   | pulse done (and err on timeout), record last-served owner
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          cpu_gnt,
  output logic          dbg_gnt,
  output logic          cpu_done,
  output logic          dbg_done,
  output logic [31:0]   rdata,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready
);

  localparam int            CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    grant;

  rr_pick2 u_pick (
    .req   ({dbg_req, cpu_req}),
    .last  (last_q),
    .grant (grant)
  );

  assign cnt_inc = cnt_q + CW'(1);
  assign rdata   = rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      last_q  <= OWN_DBG;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    cpu_done  = 1'b0;
    dbg_done  = 1'b0;
    err       = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      IDLE: begin
        // gnt is combinational off req, so it must be masked while in reset
        if (grant != 2'b00 && reset_n) begin
          cpu_gnt = grant[0];
          dbg_gnt = grant[1];
          owner_d = grant[1] ? OWN_DBG : OWN_CPU;
          we_d    = grant[1] ? dbg_we    : cpu_we;
          addr_d  = grant[1] ? dbg_addr  : cpu_addr;
          wdata_d = grant[1] ? dbg_wdata : cpu_wdata;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_read  = !we_q;
        mem_write = we_q;
        if (mem_ready) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LIMIT) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cpu_done = (owner_q == OWN_CPU);
        dbg_done = (owner_q == OWN_DBG);
        err      = err_q;
        err_d    = 1'b0;
        last_d   = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single accesses followed by
// hand-written round-robin, address-stability and mid-access reset sequences.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        reset_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, dbg_gnt, cpu_done, dbg_done, err;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_ready;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .cpu_gnt   (cpu_gnt),
    .dbg_gnt   (dbg_gnt),
    .cpu_done  (cpu_done),
    .dbg_done  (dbg_done),
    .rdata     (rdata),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;       // bit0 cpu, bit1 dbg
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_cyc;  // ACCESS cycles before mem_ready; >= TO never
    logic [31:0] mrdata;
    logic        exp_dbg;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string tag, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n_acc;
    cpu_req   = v.req[0];
    dbg_req   = v.req[1];
    cpu_we    = v.exp_dbg ? ~v.we    : v.we;
    cpu_addr  = v.exp_dbg ? ~v.addr  : v.addr;
    cpu_wdata = v.exp_dbg ? ~v.wdata : v.wdata;
    dbg_we    = v.exp_dbg ? v.we     : ~v.we;
    dbg_addr  = v.exp_dbg ? v.addr   : ~v.addr;
    dbg_wdata = v.exp_dbg ? v.wdata  : ~v.wdata;
    mem_rdata = v.mrdata;
    #2;
    chk(tag, "cpu_gnt", cpu_gnt, !v.exp_dbg);
    chk(tag, "dbg_gnt", dbg_gnt, v.exp_dbg);
    chk(tag, "idle mem_read", mem_read, 1'b0);
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    cpu_addr = 32'hFFFF_0000; dbg_addr = 32'hFFFF_0001;
    cpu_wdata = 32'h0; dbg_wdata = 32'h0;
    cpu_we = ~cpu_we; dbg_we = ~dbg_we;
    n_acc = (v.wait_cyc < TO) ? v.wait_cyc + 1 : TO;
    for (int k = 0; k < n_acc; k++) begin
      mem_ready = (k == v.wait_cyc);
      #2;
      chk(tag, "mem_read", mem_read, !v.we);
      chk(tag, "mem_write", mem_write, v.we);
      chk(tag, "mem_addr", mem_addr, v.addr);
      chk(tag, "mem_wdata", mem_wdata, v.wdata);
      chk(tag, "early done", {cpu_done, dbg_done}, 2'b00);
      tick();
    end
    mem_ready = 1'b0;
    #2;
    chk(tag, "cpu_done", cpu_done, !v.exp_dbg);
    chk(tag, "dbg_done", dbg_done, v.exp_dbg);
    chk(tag, "err", err, v.exp_err);
    chk(tag, "rdata", rdata, v.exp_rdata);
    chk(tag, "done strobes", {mem_read, mem_write}, 2'b00);
    chk(tag, "done mem_addr", mem_addr, 32'h0);
    chk(tag, "done gnt", {cpu_gnt, dbg_gnt}, 2'b00);
    tick();
  endtask

  initial begin
    vecs[0] = '{2'b01, 1'b0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{2'b10, 1'b1, 32'h20, 32'h12345678, 3, 32'h99999999, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{2'b11, 1'b0, 32'h30, 32'h0,        1, 32'hA5A50001, 1'b0, 1'b0, 32'hA5A50001};
    vecs[3] = '{2'b11, 1'b0, 32'h44, 32'h0,        0, 32'h0BADF00D, 1'b1, 1'b0, 32'h0BADF00D};
    vecs[4] = '{2'b10, 1'b0, 32'h55, 32'h0,        9, 32'h55555555, 1'b1, 1'b1, 32'h0BADF00D};
    vecs[5] = '{2'b01, 1'b0, 32'h66, 32'h0,        2, 32'h11112222, 1'b0, 1'b0, 32'h11112222};
    vecs[6] = '{2'b01, 1'b1, 32'h77, 32'hCAFEBABE, 3, 32'h99999999, 1'b0, 1'b0, 32'h11112222};
    vecs[7] = '{2'b11, 1'b1, 32'h88, 32'h0F0F0F0F, 0, 32'h99999999, 1'b1, 1'b0, 32'h11112222};

    reset_n = 1'b0;
    cpu_req = 1'b1; dbg_req = 1'b1;
    cpu_we = 1'b0; dbg_we = 1'b0;
    cpu_addr = 32'h0; dbg_addr = 32'h0; cpu_wdata = 32'h0; dbg_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    repeat (3) tick();
    chk("reset", "gnt", {cpu_gnt, dbg_gnt}, 2'b00);
    chk("reset", "done", {cpu_done, dbg_done}, 2'b00);
    chk("reset", "err", err, 1'b0);
    chk("reset", "strobes", {mem_read, mem_write}, 2'b00);
    chk("reset", "rdata", rdata, 32'h0);
    chk("reset", "mem_addr", mem_addr, 32'h0);
    cpu_req = 1'b0; dbg_req = 1'b0;
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // both requesters held for four accesses: strict alternation at 3-cycle spacing
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
    cpu_addr = 32'hC0; dbg_addr = 32'hD0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b0;
      #2;
      chk($sformatf("rr%0d", i), "cpu_gnt", cpu_gnt, (i % 2) == 0);
      chk($sformatf("rr%0d", i), "dbg_gnt", dbg_gnt, (i % 2) == 1);
      tick();
      mem_ready = 1'b1; mem_rdata = 32'h100 + i;
      #2;
      chk($sformatf("rr%0d", i), "access gnt", {cpu_gnt, dbg_gnt}, 2'b00);
      chk($sformatf("rr%0d", i), "mem_addr", mem_addr, (i % 2) ? 32'hD0 : 32'hC0);
      tick();
      mem_ready = 1'b0;
      #2;
      chk($sformatf("rr%0d", i), "done", {dbg_done, cpu_done}, (i % 2) ? 2'b10 : 2'b01);
      chk($sformatf("rr%0d", i), "done gnt", {cpu_gnt, dbg_gnt}, 2'b00);
      chk($sformatf("rr%0d", i), "rdata", rdata, 32'h100 + i);
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();

    // cpu_addr changes after grant; latched address must persist
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; mem_rdata = 32'h2468ACE0;
    #2;
    chk("addrhold", "cpu_gnt", cpu_gnt, 1'b1);
    tick();
    cpu_req = 1'b0; cpu_addr = 32'h99;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #2;
      chk("addrhold", "mem_addr", mem_addr, 32'h10);
      tick();
    end
    mem_ready = 1'b0;
    #2;
    chk("addrhold", "cpu_done", cpu_done, 1'b1);
    chk("addrhold", "rdata", rdata, 32'h2468ACE0);
    tick();

    // reset mid-ACCESS: last-served was cpu, reset must restore cpu priority
    cpu_req = 1'b1; cpu_addr = 32'h40; mem_rdata = 32'h77777777;
    #2;
    chk("rstacc", "cpu_gnt", cpu_gnt, 1'b1);
    tick();
    cpu_req = 1'b0;
    #2;
    chk("rstacc", "mem_read before", mem_read, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rstacc", "strobes dropped", {mem_read, mem_write}, 2'b00);
    chk("rstacc", "no done", {cpu_done, dbg_done}, 2'b00);
    tick();
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 32'h50; dbg_addr = 32'h60;
    #2;
    chk("rstacc", "rdata cleared", rdata, 32'h0);
    chk("rstacc", "gnt in reset", {cpu_gnt, dbg_gnt}, 2'b00);
    reset_n = 1'b1;
    #1;
    chk("rstacc", "cpu wins", {dbg_gnt, cpu_gnt}, 2'b01);
    chk("rstacc", "no done after", {cpu_done, dbg_done}, 2'b00);
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h13579BDF;
    #2;
    chk("rstacc", "mem_addr", mem_addr, 32'h50);
    tick();
    mem_ready = 1'b0;
    #2;
    chk("rstacc", "cpu_done", cpu_done, 1'b1);
    chk("rstacc", "rdata", rdata, 32'h13579BDF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum wait cycles for mem_ready before an access is aborted.
REQ-002 The block SHALL have parameter AW, default 32, meaning the address width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 cpu_req, dbg_req  input  1 each  access request from the CPU control sequencer / debug loader.
REQ-006 cpu_we, dbg_we  input  1 each  1=write, 0=read; sampled at grant.
REQ-007 cpu_addr, dbg_addr  input  AW each  word address; sampled at grant.
REQ-008 cpu_wdata, dbg_wdata  input  32 each  write data; sampled at grant.
REQ-009 cpu_gnt, dbg_gnt  output  1 each  high for exactly 1 cycle when the request is accepted.
REQ-010 cpu_done, dbg_done  output  1 each  1-cycle completion pulse to the owner.
REQ-011 rdata  output  32  read data, valid in the done cycle; held until the next done.
REQ-012 err  output  1  1-cycle pulse together with done when the access timed out.
REQ-013 mem_addr  output  AW; mem_wdata  output  32; mem_read, mem_write  output  1 each  memory port.
REQ-014 mem_rdata  input  32; mem_ready  input  1  memory completion, which may be asserted in the first access cycle.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-016 In IDLE with any req high, the block SHALL choose an owner, pulse its gnt, latch we/addr/wdata and owner, and go to ACCESS on the next edge.
REQ-017 Arbitration SHALL be round-robin: with both req high, the requester not served last SHALL win; after reset, cpu wins first.
REQ-018 With a single req high, that requester SHALL win regardless of round-robin history.
REQ-019 In ACCESS, the block SHALL drive mem_addr/mem_wdata from the latch and hold mem_read (we=0) or mem_write (we=1) high every cycle; mem_read and mem_write SHALL never both be high.
REQ-020 In ACCESS with mem_ready=1, the block SHALL capture mem_rdata into rdata on a read and go to DONE.
REQ-021 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without mem_ready.
REQ-022 When the count reaches TIMEOUT, the block SHALL drop mem_read/mem_write, leave rdata unchanged, set a pending error flag and go to DONE.
REQ-023 In DONE, the block SHALL pulse the owner's done, pulse err if the error flag is set, clear the flag, update last-served to the owner and return to IDLE; memory strobes SHALL be low.
REQ-024 Minimum latency SHALL be: gnt in cycle 0, ACCESS in cycle 1 (mem_ready=1), done in cycle 2; the next grant SHALL be no earlier than cycle 3.
REQ-025 Requests SHALL be level-sensitive and SHALL NOT be queued; a requester dropping req before grant is ignored; req held through its own done SHALL re-arbitrate in the following IDLE.
REQ-026 A change on req/we/addr/wdata after grant SHALL NOT affect the in-flight access.
REQ-027 At most one gnt and one done SHALL be high per cycle.
REQ-028 Outside ACCESS, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-029 While reset_n=0, the block SHALL hold state=IDLE, all gnt/done/err/mem_read/mem_write=0, rdata=0, counter=0, last-served=dbg (so cpu wins first), and the latches at 0.
REQ-030 reset_n falling mid-ACCESS SHALL abort the access immediately and emit no done; operation SHALL resume on the first posedge after release.

Structure
REQ-031 A shared package SHALL hold the arb_state_t enum (IDLE, ACCESS, DONE), the owner encoding OWN_CPU=0 / OWN_DBG=1 and the default TIMEOUT constant.
REQ-032 The 2-way round-robin pick SHALL be a combinational sub-module rr_pick2 (inputs req[1:0] and last; outputs grant one-hot).
REQ-033 The expected implementation size is 150-250 lines.

Verification
REQ-034 cpu read of addr 0x10, mem_ready=1 the first ACCESS cycle with mem_rdata=0xDEADBEEF -> cpu_gnt cycle 0, mem_read cycle 1, cpu_done and rdata=0xDEADBEEF cycle 2.
REQ-035 cpu_req and dbg_req held high together for 4 accesses -> grant order cpu, dbg, cpu, dbg.
REQ-036 dbg write addr 0x20 data 0x12345678, mem_ready after 3 wait cycles -> mem_write high for 4 cycles, addr/data stable, dbg_done once, err=0.
REQ-037 TIMEOUT=4, mem_ready stuck 0 -> strobes drop after 4 cycles, done and err pulse together, rdata unchanged, next request granted normally.
REQ-038 reset_n pulsed low during ACCESS -> strobes drop immediately, no done; after release cpu wins a simultaneous request.
REQ-039 cpu_addr changed from 0x10 to 0x99 one cycle after cpu_gnt -> mem_addr stays 0x10 for the whole access.
